gamepad_reader: RTL and testbench



---
 rtl/gamepad_reader.sv | 146 ++++++++++++++
 tb/tb_gamepad_reader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gamepad_reader.sv
// NES-style gamepad poller: latches, clocks out and deserialises eight active-low buttons.
// Outputs are registered, active-high, and refreshed only when a full scan completes (valid pulse).
module gamepad_reader #(
  parameter int HALF_PERIOD = 150,
  parameter int POLL_CYCLES = 416667
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic A,
  output logic B,
  output logic select,
  output logic start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic valid
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = $clog2(2 * HALF_PERIOD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      sync_q;
  logic            data_s;
  logic [PW-1:0]   poll_cnt;
  logic            tick;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [7:0]      shreg_nxt;
  logic [7:0]      btn;

  // Synchroniser idles high so a floating/pulled-up line reads as "not pressed".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], pad_data};
  end
  assign data_s = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                poll_cnt <= PW'(POLL_CYCLES - 1);
    else if (poll_cnt == '0)  poll_cnt <= PW'(POLL_CYCLES - 1);
    else                      poll_cnt <= poll_cnt - 1'b1;
  end
  assign tick = (poll_cnt == '0);

  // Shift register with the current bit merged in, so bit 7 reaches the outputs on the same edge.
  always_comb begin
    shreg_nxt          = shreg;
    shreg_nxt[bit_idx] = data_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= 8'hFF;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      btn       <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            state     <= S_LATCH;
            timer     <= TW'(2 * HALF_PERIOD - 1);
            pad_latch <= 1'b1;
          end
        end
        S_LATCH: begin
          if (timer == '0) begin
            state     <= S_LOW;
            timer     <= TW'(HALF_PERIOD - 1);
            pad_latch <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_LOW: begin
          if (timer == '0) begin
            shreg <= shreg_nxt;
            if (bit_idx == 3'd7) begin
              state <= S_DONE;
              timer <= '0;
              btn   <= ~shreg_nxt;
              valid <= 1'b1;
            end else begin
              state   <= S_HIGH;
              timer   <= TW'(HALF_PERIOD - 1);
              bit_idx <= bit_idx + 3'd1;
              pad_clk <= 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_HIGH: begin
          if (timer == '0) begin
            state   <= S_LOW;
            timer   <= TW'(HALF_PERIOD - 1);
            pad_clk <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          timer   <= '0;
          bit_idx <= '0;
        end
        default: begin
          state     <= S_IDLE;
          timer     <= '0;
          bit_idx   <= '0;
          pad_latch <= 1'b0;
          pad_clk   <= 1'b0;
        end
      endcase
    end
  end

  assign A      = btn[0];
  assign B      = btn[1];
  assign select = btn[2];
  assign start  = btn[3];
  assign up     = btn[4];
  assign down   = btn[5];
  assign left   = btn[6];
  assign right  = btn[7];

endmodule

// File: tb/tb_gamepad_reader.sv
// Bench for gamepad_reader: pad shift-register model plus a per-cycle timing/button reference.
module tb_gamepad_reader;
  localparam int H    = 4;
  localparam int P    = 100;
  localparam int SCAN = 17 * H;

  typedef struct {
    logic [7:0] wire_v;
    logic [7:0] exp_btn;
    logic [7:0] next_wire;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pad_data;
  logic pad_latch, pad_clk, A, B, select, start, up, down, left, right, valid;
  logic [7:0] btn;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] pad_byte = 8'hFF;
  logic [7:0] snap     = 8'hFF;
  logic [3:0] pad_idx  = 4'd8;
  logic       disc     = 1'b0;

  always #5 clk = ~clk;

  gamepad_reader #(.HALF_PERIOD(H), .POLL_CYCLES(P)) dut (
    .clk(clk), .reset(reset), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .A(A), .B(B), .select(select), .start(start),
    .up(up), .down(down), .left(left), .right(right),
    .valid(valid)
  );

  assign btn = {right, left, down, up, start, select, B, A};

  // Pad: parallel load on latch, next bit presented on each rising pad_clk.
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) begin
      snap    = pad_byte;
      pad_idx = 4'd0;
    end else begin
      pad_idx = pad_idx + 4'd1;
    end
  end
  assign pad_data = disc ? 1'b1 : ((pad_idx < 4'd8) ? snap[pad_idx[2:0]] : 1'b1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pin levels t cycles after the latch rises.
  function automatic logic exp_latch(input int t);
    return (t >= 0) && (t < 2 * H);
  endfunction

  function automatic logic exp_clk(input int t);
    for (int k = 1; k < 8; k++)
      if (t >= 3 * H + 2 * (k - 1) * H && t < 4 * H + 2 * (k - 1) * H) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_valid(input int t);
    return t == SCAN;
  endfunction

  task automatic reset_and_idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_latch", pad_latch, 0);
    check("rst_clk", pad_clk, 0);
    check("rst_btn", btn, 0);
    check("rst_valid", valid, 0);
    reset = 1'b0;
    begin
      logic lat_seen = 1'b0;
      logic val_seen = 1'b0;
      logic clk_seen = 1'b0;
      for (int t = 1; t < P; t++) begin
        @(posedge clk); #1;
        lat_seen |= pad_latch;
        val_seen |= valid;
        clk_seen |= pad_clk;
      end
      check("idle_latch", lat_seen, 0);
      check("idle_valid", val_seen, 0);
      check("idle_clk", clk_seen, 0);
      check("idle_btn", btn, 0);
    end
  endtask

  // Runs one poll period starting at the edge that raises the latch.
  task automatic run_scan(input string tag, input logic [7:0] wire_v, input logic [7:0] prev_btn,
                          input logic [7:0] exp_btn, input logic [7:0] next_wire, input int abort_t);
    int pulses = 0;
    int valids = 0;
    logic last_clk = 1'b0;
    pad_byte = wire_v;
    for (int t = 0; t < P; t++) begin
      @(posedge clk); #1;
      if (t == abort_t) begin
        check($sformatf("%s_pre_abort_clk", tag), pad_clk, 1);
        reset = 1'b1;
        #1;
        check($sformatf("%s_abort_clk", tag), pad_clk, 0);
        check($sformatf("%s_abort_latch", tag), pad_latch, 0);
        check($sformatf("%s_abort_btn", tag), btn, 0);
        check($sformatf("%s_abort_valid", tag), valid, 0);
        return;
      end
      check($sformatf("%s_latch@%0d", tag, t), pad_latch, exp_latch(t));
      check($sformatf("%s_clk@%0d", tag, t), pad_clk, exp_clk(t));
      check($sformatf("%s_valid@%0d", tag, t), valid, exp_valid(t));
      check($sformatf("%s_btn@%0d", tag, t), btn, (t < SCAN) ? prev_btn : exp_btn);
      if (pad_clk && !last_clk) pulses++;
      last_clk = pad_clk;
      if (valid) valids++;
      if (t == 7 * H + 1) pad_byte = next_wire;
    end
    check($sformatf("%s_pulses", tag), pulses, 7);
    check($sformatf("%s_valids", tag), valids, 1);
  endtask

  initial begin
    vec_t vecs[7];
    logic [7:0] prev;
    logic [7:0] w;

    vecs[0] = '{8'hFE, 8'h01, 8'hFE};
    vecs[1] = '{8'h7F, 8'h80, 8'h7F};
    vecs[2] = '{8'h00, 8'hFF, 8'h00};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF};
    vecs[4] = '{8'h5A, 8'hA5, 8'h3C};
    vecs[5] = '{8'h3C, 8'hC3, 8'h3C};
    vecs[6] = '{8'hA5, 8'h5A, 8'hA5};

    reset_and_idle();
    prev = 8'h00;
    for (int i = 0; i < 7; i++) begin
      run_scan($sformatf("vec%0d", i), vecs[i].wire_v, prev, vecs[i].exp_btn, vecs[i].next_wire, -1);
      prev = vecs[i].exp_btn;
    end

    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom);
      run_scan($sformatf("rnd%0d", i), w, prev, ~w, w, -1);
      prev = ~w;
    end

    // Reset in the HIGH phase of bit 4, then a clean scan from power-up state.
    w = 8'h33;
    run_scan("abort", w, prev, ~w, w, 3 * H + 6 * H + 1);
    reset_and_idle();
    run_scan("post_rst", 8'h96, 8'h00, 8'h69, 8'h96, -1);
    prev = 8'h69;

    disc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = 8'($urandom);
      run_scan($sformatf("disc%0d", i), w, prev, 8'h00, w, -1);
      prev = 8'h00;
    end
    disc = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
